keypad_debouncer: RTL and testbench



---
 rtl/keypad_debouncer.sv | 147 ++++++++++++++
 tb/tb_keypad_debouncer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/keypad_debouncer.sv
// Twelve-key synchroniser + per-key debouncer with registered press pulses and key code.
// Optional auto-repeat of the lowest held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_RATE     = 10000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [11:0] Raw_key,
  output logic [11:0] Key_level,
  output logic [11:0] Key_press,
  output logic        Key_valid,
  output logic [3:0]  Key_code
);

  localparam int              NK      = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || (CNT_W < 31 && (1 << CNT_W) <= DEBOUNCE_CYCLES)) begin : g_bad_debounce
    $error("keypad_debouncer: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("keypad_debouncer: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  function automatic logic [3:0] lowest_idx(input logic [NK-1:0] v);
    lowest_idx = 4'd0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  logic [NK-1:0]    r_sync_p0;
  logic [NK-1:0]    r_sync_p1;
  logic [NK-1:0]    r_stable;
  logic [CNT_W-1:0] r_cnt [NK];
  logic [NK-1:0]    r_press;
  logic             r_valid;
  logic [3:0]       r_code;

  logic [NK-1:0]    w_rise;
  logic [NK-1:0]    w_press_nxt;

  // Stage p0/p1: two-flop synchroniser; then per-key debounce into r_stable
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_stable  <= '0;
      for (int i = 0; i < NK; i++) r_cnt[i] <= '0;
    end else begin
      r_sync_p0 <= Raw_key;
      r_sync_p1 <= r_sync_p0;
      for (int i = 0; i < NK; i++) begin
        if (r_sync_p1[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync_p1[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A rise is accepted on the same edge r_stable goes high, so the pulse aligns with Key_level
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < NK; i++) begin
      w_rise[i] = (r_cnt[i] == CNT_MAX) & r_sync_p1[i] & ~r_stable[i];
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_rep_act;
  logic              r_rep_phase;
  logic [3:0]        r_rep_idx;

  logic [3:0]        w_rep_idx;
  logic [HOLD_W-1:0] w_hold_tgt;
  logic              w_any;
  logic              w_fire;

  always_comb begin
    w_rep_idx  = lowest_idx(r_stable);
    w_any      = |r_stable;
    w_hold_tgt = r_rep_phase ? HOLD_W'(REPEAT_RATE - 1) : HOLD_W'(REPEAT_DELAY - 1);
    w_fire     = w_any & r_rep_act & (w_rep_idx == r_rep_idx) & (r_hold == w_hold_tgt);
    w_press_nxt = w_rise;
    if (w_fire) w_press_nxt = w_rise | (NK'(1) << w_rep_idx);
  end

  // Tracking starts one edge after the level rises, hence the hold count starts at 1
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hold      <= '0;
      r_rep_act   <= 1'b0;
      r_rep_phase <= 1'b0;
      r_rep_idx   <= 4'd0;
    end else if (!w_any) begin
      r_hold      <= '0;
      r_rep_act   <= 1'b0;
      r_rep_phase <= 1'b0;
    end else if (!r_rep_act || (w_rep_idx != r_rep_idx)) begin
      r_hold      <= HOLD_W'(1);
      r_rep_act   <= 1'b1;
      r_rep_phase <= 1'b0;
      r_rep_idx   <= w_rep_idx;
    end else if (w_fire) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b1;
    end else begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end
`else
  always_comb begin
    w_press_nxt = w_rise;
  end
`endif

  // Stage p2: registered press vector, valid and priority code
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_press <= '0;
      r_valid <= 1'b0;
      r_code  <= 4'd0;
    end else begin
      r_press <= w_press_nxt;
      r_valid <= |w_press_nxt;
      r_code  <= lowest_idx(w_press_nxt);
    end
  end

  assign Key_level = r_stable;
  assign Key_press = r_press;
  assign Key_valid = r_valid;
  assign Key_code  = r_code;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Scoreboard bench for keypad_debouncer (DEBOUNCE_CYCLES=4): expected press events are queued
// by the stimulus and popped by a monitor whenever the DUT presents a pulse.
module tb_keypad_debouncer;
  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic [11:0] press;
    logic [3:0]  code;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] Raw_key = '0;
  logic [11:0] Key_level;
  logic [11:0] Key_press;
  logic        Key_valid;
  logic [3:0]  Key_code;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  keypad_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Raw_key(Raw_key),
    .Key_level(Key_level),
    .Key_press(Key_press),
    .Key_valid(Key_valid),
    .Key_code(Key_code)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Raw change driven at a negedge with cyc=c shows up as a pulse sampled at cyc=c+D+2
  task automatic press_key(input logic [11:0] mask, input logic [11:0] vec, input logic [3:0] code);
    exp_t e;
    Raw_key = Raw_key | mask;
    e.cyc   = cyc + D + 2;
    e.press = vec;
    e.code  = code;
    q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST && (Key_valid || Key_press != 12'h000)) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: got press=%03h valid=%0d code=%0d, expected no pulse (cycle %0d)",
                 Key_press, Key_valid, Key_code, cyc);
      end else begin
        e = q.pop_front();
        chk("press_cycle", cyc, e.cyc);
        chk("press_vec", {20'd0, Key_press}, {20'd0, e.press});
        chk("press_code", {28'd0, Key_code}, {28'd0, e.code});
        chk("press_valid", {31'd0, Key_valid}, 32'd1);
      end
    end
  end

  initial begin
    logic       seen5;
    logic [7:0] pat;
    #2 RST = 1'b0;
    wait_neg(2);
    chk("rst_level", {20'd0, Key_level}, 32'd0);
    chk("rst_press", {20'd0, Key_press}, 32'd0);
    chk("rst_valid", {31'd0, Key_valid}, 32'd0);
    chk("rst_code", {28'd0, Key_code}, 32'd0);
    RST = 1'b1;
    wait_neg(3);

    // Single press of key 0 and exact level timing
    press_key(12'h001, 12'h001, 4'd0);
    wait_neg(D + 1);
    chk("k0_level_before", {31'd0, Key_level[0]}, 32'd0);
    wait_neg(1);
    chk("k0_level_after", {31'd0, Key_level[0]}, 32'd1);
    wait_neg(20);
    Raw_key[0] = 1'b0;
    wait_neg(10);
    chk("k0_released", {31'd0, Key_level[0]}, 32'd0);

    // Bouncing key 5: two 3-cycle highs never reach the threshold
    seen5 = 1'b0;
    pat   = 8'b11100111;
    for (int i = 0; i < 16; i++) begin
      Raw_key[5] = (i < 8) ? pat[7 - i] : 1'b0;
      @(negedge CLK);
      seen5 = seen5 | Key_level[5];
    end
    chk("glitch_level5", {31'd0, seen5}, 32'd0);
    chk("idle_code", {28'd0, Key_code}, 32'd0);

    // Simultaneous presses of keys 11 and 3
    press_key(12'h808, 12'h808, 4'd3);
    wait_neg(10);
    chk("dual_level", {20'd0, Key_level}, 32'h808);
    Raw_key = '0;
    wait_neg(10);

    // Key 7 press then release: level falls D+2 edges later, no pulse
    press_key(12'h080, 12'h080, 4'd7);
    wait_neg(10);
    Raw_key[7] = 1'b0;
    wait_neg(D + 1);
    chk("k7_rel_before", {31'd0, Key_level[7]}, 32'd1);
    wait_neg(1);
    chk("k7_rel_after", {31'd0, Key_level[7]}, 32'd0);
    wait_neg(5);

    // Reset while key 1 is held: immediate clear, fresh pulse after release
    press_key(12'h002, 12'h002, 4'd1);
    wait_neg(10);
    chk("k1_level_held", {20'd0, Key_level}, 32'h002);
    RST = 1'b0;
    #1;
    chk("rst_mid_level", {20'd0, Key_level}, 32'd0);
    chk("rst_mid_valid", {31'd0, Key_valid}, 32'd0);
    wait_neg(2);
    RST = 1'b1;
    press_key(12'h002, 12'h002, 4'd1);
    wait_neg(10);
    chk("k1_level_again", {20'd0, Key_level}, 32'h002);
    Raw_key[1] = 1'b0;
    wait_neg(10);

    // Key 4 held while key 6 glitches for 2 cycles alongside it
    press_key(12'h050, 12'h010, 4'd4);
    wait_neg(2);
    Raw_key[6] = 1'b0;
    wait_neg(10);
    chk("indep_level", {20'd0, Key_level}, 32'h010);
    Raw_key = '0;
    wait_neg(12);
    chk("final_level", {20'd0, Key_level}, 32'd0);
    chk("queue_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
